alu_cmd_driver: RTL and testbench

Sequential front-end that drives the team's 4-bit combinational ALU (alu) from a nibble-serial command stream. It collects opcode and operands over a valid/ready input handshake and presents them to the ALU. It captures the ALU result and flags, and returns them over a valid/ready response handshake. An internal accumulator lets results be chained without re-sending operand A.

---
 rtl/alu_cmd_driver_pkg.sv | 43 ++++
 rtl/alu_cmd_driver.sv | 114 +++++++++++
 tb/tb_alu_cmd_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the nibble-serial ALU command driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cmd_driver_pkg;

    // ALU opcodes, passed through to the ALU unchanged
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    // ALU flag bit positions
    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    // Header nibble layout: {use_acc, opcode[2:0]}
    localparam int USE_ACC_BIT = 3;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,
        S_A   = 3'd1,
        S_B   = 3'd2,
        S_EX  = 3'd3,
        S_RSP = 3'd4
    } state_t;

    // Opcode field of a header nibble
    function automatic logic [2:0] hdr_opcode(input logic [3:0] hdr);
        return hdr[2:0];
    endfunction

    // Accumulator-select field of a header nibble
    function automatic logic hdr_use_acc(input logic [3:0] hdr);
        return hdr[USE_ACC_BIT];
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Collects {header, A, B} nibbles, drives the external ALU from registers, returns {flags, result}.
// Latency: one execute cycle after operand B is taken, then the response is held until accepted.
// Backpressure: cmd_ready drops from execute until the response transfers; rsp_data holds while rsp_ready=0.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   ACC_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*W-1:0]   rsp_data,
    output logic [W-1:0]     alu_in1,
    output logic [W-1:0]     alu_in2,
    output logic [2:0]       alu_opcode,
    input  logic [W-1:0]     alu_out,
    input  logic [3:0]       alu_flags,
    output logic [W-1:0]     acc
);

    state_t         state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic [3:0]     flg_q;
    logic [W-1:0]   acc_q;
    logic           cmd_ready_q;
    logic           rsp_valid_q;

    logic           cmd_xfer;
    logic           rsp_xfer;

    assign cmd_xfer = cmd_valid && cmd_ready_q;
    assign rsp_xfer = rsp_valid_q && rsp_ready;

    // Command FSM: gathers nibbles, runs one execute cycle, then holds the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OP;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            flg_q       <= '0;
            acc_q       <= ACC_RST;
        end else begin
            case (state)
                S_OP: begin
                    if (cmd_xfer) begin
                        op_q <= hdr_opcode(cmd_data);
                        // Chained ops reuse the accumulator as A and skip the A nibble
                        if (hdr_use_acc(cmd_data)) begin
                            a_q   <= acc_q;
                            state <= S_B;
                        end else begin
                            state <= S_A;
                        end
                    end
                end
                S_A: begin
                    if (cmd_xfer) begin
                        a_q   <= cmd_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    // B is always collected, even for unary opcodes that ignore it
                    if (cmd_xfer) begin
                        b_q         <= cmd_data;
                        state       <= S_EX;
                        cmd_ready_q <= 1'b0;
                    end
                end
                S_EX: begin
                    // ALU inputs have been stable from registers for this whole cycle
                    res_q       <= alu_out;
                    flg_q       <= alu_flags;
                    acc_q       <= alu_out;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_xfer) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_OP;
                    end
                end
                default: begin
                    state       <= S_OP;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = {flg_q, res_q};
    assign alu_in1    = a_q;
    assign alu_in2    = b_q;
    assign alu_opcode = op_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [2:0] alu_opcode;
    logic [3:0] alu_out;
    logic [3:0] alu_flags;
    logic [3:0] acc;

    int tests = 0;
    int fails = 0;
    logic [3:0] m_acc;

    alu_cmd_driver #(.W(4), .ACC_RST(4'b0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU: returns {N, Z, V, C, result}
    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int s;
        int r;
        logic c;
        logic v;
        logic [3:0] res;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = s % 16;
                c = (s > 15);
                v = (a[3] == b[3]) && (r >= 8) != a[3];
            end
            3'd1: begin
                s = int'(a) - int'(b);
                r = (s + 16) % 16;
                c = (a >= b);
                v = (a[3] != b[3]) && ((r >= 8) != a[3]);
            end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = 15 - int'(a);
            3'd5: r = int'(a ^ b);
            3'd6: begin
                r = (16 - int'(a)) % 16;
                c = (a == 4'd0);
                v = (a == 4'd8);
            end
            default: begin
                r = (int'(a) * 2) % 16;
                c = a[3];
            end
        endcase
        res = r[3:0];
        return {res[3], res == 4'd0, v, c, res};
    endfunction

    // The bench stands in for the external ALU
    always_comb begin
        logic [7:0] t;
        t = alu_ref(alu_opcode, alu_in1, alu_in2);
        alu_flags = t[7:4];
        alu_out   = t[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the nibble transferred
    task automatic send_nib(input logic [3:0] n, input int gap);
        int t;
        cmd_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        cmd_valid = 1'b1;
        cmd_data  = n;
        t = 0;
        while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) chk("cmd_ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
    endtask

    task automatic get_rsp(input int rdly, output logic [7:0] d);
        int t;
        t = 0;
        while (!rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) chk("rsp_valid_timeout", 32'd1, 32'd0);
        repeat (rdly) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        d = rsp_data;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Sends one full command and returns the response together with the model's prediction
    task automatic do_cmd(input logic [3:0] hdr, input logic [3:0] a, input logic [3:0] b,
                          input int gap, input int rdly,
                          output logic [7:0] got, output logic [7:0] exp);
        logic [3:0] a_eff;
        a_eff = hdr[3] ? m_acc : a;
        exp   = alu_ref(hdr[2:0], a_eff, b);
        send_nib(hdr, gap);
        if (!hdr[3]) send_nib(a, gap);
        send_nib(b, gap);
        get_rsp(rdly, got);
        m_acc = exp[3:0];
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] held;
        logic [3:0] h;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
        rsp_ready = 1'b0;
        m_acc     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h00);
        chk("rst_alu_in", 32'({alu_in1, alu_in2, alu_opcode}), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        rst_n = 1'b1;

        // Add 3+5
        do_cmd(4'h0, 4'h3, 4'h5, 0, 0, got, exp);
        chk("add_rsp", 32'(got), 32'hA8);
        chk("add_model", 32'(got), 32'(exp));
        chk("add_acc", 32'(acc), 32'h8);

        // Accumulator chain: 8+1
        do_cmd(4'h8, 4'h0, 4'h1, 0, 0, got, exp);
        chk("chain_rsp", 32'(got), 32'h89);
        chk("chain_acc", 32'(acc), 32'h9);

        // Subtract to zero
        do_cmd(4'h1, 4'h5, 4'h5, 0, 0, got, exp);
        chk("sub_rsp", 32'(got), 32'h50);
        chk("sub_acc", 32'(acc), 32'h0);

        // Stalled source: and C&A with 3-cycle gaps
        do_cmd(4'h2, 4'hC, 4'hA, 3, 0, got, exp);
        chk("and_rsp", 32'(got), 32'h88);

        // Latency: execute cycle, then response in the following cycle
        send_nib(4'h8, 0);
        send_nib(4'h2, 0);
        chk("lat_ex_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("lat_ex_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_rsp_data", 32'(rsp_data), 32'(alu_ref(3'd0, m_acc, 4'h2)));
        m_acc = alu_ref(3'd0, m_acc, 4'h2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("lat_post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("lat_post_rsp_valid", 32'(rsp_valid), 32'd0);

        // Backpressure: hold response for 10 cycles with a pending header offered
        send_nib(4'h0, 0);
        send_nib(4'h6, 0);
        send_nib(4'h7, 0);
        @(posedge clk); #1;
        held = rsp_data;
        chk("bp_first", 32'(held), 32'(alu_ref(3'd0, 4'h6, 4'h7)));
        m_acc = held[3:0];
        cmd_valid = 1'b1;
        cmd_data  = 4'h3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_data", 32'(rsp_data), 32'(held));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_released_valid", 32'(rsp_valid), 32'd0);
        chk("bp_released_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a command
        send_nib(4'h0, 0);
        send_nib(4'h7, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_alu_in1", 32'(alu_in1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_acc = 4'h0;
        do_cmd(4'h8, 4'h0, 4'h3, 0, 0, got, exp);
        chk("post_rst_chain", 32'(got), 32'h03);
        do_cmd(4'h0, 4'h2, 4'h6, 0, 0, got, exp);
        chk("post_rst_add", 32'(got), 32'hA8);

        // Randomized commands against the model
        for (int i = 0; i < 60; i++) begin
            h = 4'($urandom);
            do_cmd(h, 4'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), got, exp);
            chk("rand_rsp", 32'(got), 32'(exp));
            chk("rand_acc", 32'(acc), 32'(m_acc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
